// File: rtl/boot_run_ctrl.sv
// Load/run/halt sequencer: streams a program into IMEM, holds the core in reset
// while loading, releases it to run and captures exit status on ebreak.
module boot_run_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          MAX_WORDS   = 4096,
   parameter int          CYC_W       = 32,
   parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_load,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [31:0]      load_data,
   input  logic             load_last,
   output logic             rom_we,
   output logic [31:0]      rom_waddr,
   output logic [31:0]      rom_wdata,
   output logic             core_rst,
   input  logic [31:0]      inst,
   input  logic [31:0]      pc,
   input  logic [31:0]      a0,
   output logic             halted,
   output logic             err,
   output logic [31:0]      exit_code,
   output logic [31:0]      halt_pc,
   output logic [CYC_W-1:0] cycle_count,
   output logic [15:0]      word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_HALT,
      S_ERROR
   } state_t;

   localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

   state_t      r_state;
   logic [31:0] w_beatAddr;
   logic        w_full;
   logic        w_cycMax;

   assign load_ready = (r_state == S_LOAD);
   // Beat n lands at BASE_ADDR + 4n; word_count already holds n at accept time.
   assign w_beatAddr = BASE_ADDR + {14'd0, word_count, 2'b00};
   assign w_full     = (word_count == MAX_W16);
   assign w_cycMax   = &cycle_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         core_rst    <= 1'b1;
         rom_we      <= 1'b0;
         rom_waddr   <= '0;
         rom_wdata   <= '0;
         halted      <= 1'b0;
         err         <= 1'b0;
         exit_code   <= '0;
         halt_pc     <= '0;
         cycle_count <= '0;
         word_count  <= '0;
      end else begin
         rom_we <= 1'b0;
         // A load request restarts everything from any state except SETTLE and
         // takes priority over a simultaneous ebreak or beat.
         if (start_load && (r_state != S_SETTLE)) begin
            r_state     <= S_LOAD;
            core_rst    <= 1'b1;
            halted      <= 1'b0;
            err         <= 1'b0;
            exit_code   <= '0;
            halt_pc     <= '0;
            cycle_count <= '0;
            word_count  <= '0;
         end else begin
            case (r_state)
               S_IDLE: ;
               S_LOAD: begin
                  if (load_valid) begin
                     if (w_full) begin
                        r_state <= S_ERROR;
                        err     <= 1'b1;
                     end else begin
                        rom_we     <= 1'b1;
                        rom_waddr  <= w_beatAddr;
                        rom_wdata  <= load_data;
                        word_count <= word_count + 16'd1;
                        if (load_last) begin
                           r_state <= S_SETTLE;
                        end
                     end
                  end
               end
               S_SETTLE: begin
                  r_state  <= S_RUN;
                  core_rst <= 1'b0;
               end
               S_RUN: begin
                  if (!w_cycMax) begin
                     cycle_count <= cycle_count + 1'b1;
                  end
                  if (inst == EBREAK_INST) begin
                     r_state   <= S_HALT;
                     core_rst  <= 1'b1;
                     halted    <= 1'b1;
                     exit_code <= a0;
                     halt_pc   <= pc;
                  end
               end
               S_HALT: ;
               S_ERROR: ;
               default: begin
                  r_state  <= S_IDLE;
                  core_rst <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
